mem_line_ctrl: RTL and testbench
================================

# mem_line_ctrl

- Line-granularity backing-memory controller, directly downstream of the data cache.
- Accepts one miss request at a time: 128-bit line refill, optionally preceded by a dirty-line writeback.
- Models a fixed access latency per phase and returns refill data with a ready/ack handshake.
- Holds the line storage array that the cache refills from and writes back to.

## Interface
Parameters:
- LATENCY, 5, cycles per memory phase (writeback or refill); legal range 1..255
- DEPTH_LOG2, 10, log2 of number of 128-bit lines stored

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears controller state
- req  in  1  miss request from cache; level, held until refill data is consumed
- req_addr  in  26  line address of refill
- wb_en  in  1  request includes writeback of a dirty line; sampled with req
- wb_addr  in  26  line address of writeback
- wb_data  in  128  dirty line contents
- stop  in  1  freeze: latency counter and FSM hold while high
- data_out  out  128  refill line, registered
- read_ready  out  1  data_out valid; held until req drops
- write_ack  out  1  one-cycle pulse, writeback committed
- busy  out  1  high in any state other than IDLE

## Operation
- Storage: 2^DEPTH_LOG2 x 128 bits. Index = addr[DEPTH_LOG2-1:0]; upper address bits ignored. Reset does not clear storage.
- FSM states: IDLE, WB_WAIT, RD_WAIT, RD_DONE.
- IDLE: on a posedge with req=1 and stop=0:
  - latch req_addr, wb_addr, wb_data; load counter with LATENCY-1.
  - go to WB_WAIT if wb_en=1, else RD_WAIT.
- WB_WAIT: decrement the counter each unstalled cycle. On the cycle the counter is 0:
  - write the latched wb_data to storage[wb_addr index];
  - assert write_ack for the following cycle;
  - reload counter with LATENCY-1 and go to RD_WAIT.
- RD_WAIT: decrement the counter each unstalled cycle. On the cycle the counter is 0:
  - register storage[req_addr index] into data_out;
  - set read_ready and go to RD_DONE.
- RD_DONE: hold data_out and read_ready. On the first posedge sampling req=0, clear read_ready and return to IDLE.
- Writeback precedes refill. A refill of the same line as the writeback returns the written data.
- Inputs changing after acceptance are ignored; only latched values are used.
- stop=1 freezes counter and state in WB_WAIT/RD_WAIT, and blocks acceptance in IDLE. RD_DONE still exits on req=0.
- req dropping in WB_WAIT or RD_WAIT is ignored; the transaction completes and waits in RD_DONE for req=0.

## Timing
- Reset values: data_out=0, read_ready=0, write_ack=0, busy=0, state IDLE, counter 0.
- Asynchronous reset mid-transaction aborts it: any pending storage write is dropped, and outputs return to reset values immediately.
- Read only: req accepted at edge k → read_ready high after edge k+LATENCY.
- With writeback:
  - write_ack high for exactly the cycle after edge k+LATENCY;
  - read_ready high after edge k+2*LATENCY.
- Each stalled cycle (stop=1 in a WAIT state) adds one cycle to the above.
- busy rises after the acceptance edge and falls with read_ready.
- Back-to-back requests: minimum one IDLE cycle between transactions.
- LATENCY=1: each phase completes on the edge after entering it.

## Test plan
- Read only: preload line 5 = 0x0123...CDEF; req=1, req_addr=5, wb_en=0 at edge 0, LATENCY=5 → read_ready rises after edge 5 with data_out=0x0123...CDEF; drop req → read_ready=0 and busy=0 after next edge.
- Writeback + refill: wb_addr=3, wb_data=0xAAAA...AAAA, req_addr=7 at edge 0 → write_ack is a single pulse after edge 5, storage[3]=0xAAAA..., read_ready after edge 10 with storage[7] contents.
- Same-line writeback/refill: wb_addr=req_addr=9, wb_data=0x5555... → data_out=0x5555... after edge 10.
- Stall: stop=1 for 3 cycles during RD_WAIT on a read-only request → read_ready after edge 8 instead of 5; no outputs change while stalled.
- Reset mid-op: assert reset asynchronously during WB_WAIT → busy, read_ready, write_ack all 0 immediately; write_ack never pulses; storage[wb_addr] unchanged.
- Aliasing/latching: DEPTH_LOG2=10, req_addr=0x0400 → returns line 0; change req_addr after acceptance → data_out unaffected.

Source files
------------

// File: rtl/mem_line_ctrl.sv
// Line-granularity backing memory behind the data cache: one miss at a time,
// optional dirty-line writeback, then a 128-bit refill after a fixed per-phase latency.
module mem_line_ctrl #(
    parameter int unsigned LATENCY    = 5,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         req_i,
    input  logic [25:0]  req_addr_i,
    input  logic         wb_en_i,
    input  logic [25:0]  wb_addr_i,
    input  logic [127:0] wb_data_i,
    input  logic         stop_i,
    output logic [127:0] data_out_o,
    output logic         read_ready_o,
    output logic         write_ack_o,
    output logic         busy_o
);

    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [7:0]  CNT_RELOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WB_WAIT = 2'd1,
        RD_WAIT = 2'd2,
        RD_DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   rd_idx_q, rd_idx_d;
    logic [DEPTH_LOG2-1:0]   wb_idx_q, wb_idx_d;
    logic [127:0]            wb_data_q, wb_data_d;
    logic [127:0]            data_out_q;
    logic                    read_ready_q, read_ready_d;
    logic                    write_ack_q, write_ack_d;

    logic [127:0]            mem_q [DEPTH];

    logic                    accept;
    logic                    wb_fire;
    logic                    rd_fire;
    logic                    rd_exit;
    logic                    waiting;
    logic                    busy;

    // Line index aliases: address bits above the index are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr_i[25:DEPTH_LOG2], wb_addr_i[25:DEPTH_LOG2]};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_i && !stop_i) begin
                    state_d = wb_en_i ? WB_WAIT : RD_WAIT;
                end
            end
            WB_WAIT: begin
                if (!stop_i && (cnt_q == 8'd0)) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (!stop_i && (cnt_q == 8'd0)) begin
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                if (!req_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept  = 1'b0;
        wb_fire = 1'b0;
        rd_fire = 1'b0;
        rd_exit = 1'b0;
        waiting = 1'b0;
        busy    = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy   = 1'b0;
                accept = req_i && !stop_i;
            end
            WB_WAIT: begin
                waiting = 1'b1;
                wb_fire = !stop_i && (cnt_q == 8'd0);
            end
            RD_WAIT: begin
                waiting = 1'b1;
                rd_fire = !stop_i && (cnt_q == 8'd0);
            end
            RD_DONE: begin
                rd_exit = !req_i;
            end
            default: busy = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        rd_idx_d     = rd_idx_q;
        wb_idx_d     = wb_idx_q;
        wb_data_d    = wb_data_q;
        read_ready_d = read_ready_q;
        write_ack_d  = wb_fire;

        if (accept) begin
            cnt_d     = CNT_RELOAD;
            rd_idx_d  = req_addr_i[DEPTH_LOG2-1:0];
            wb_idx_d  = wb_addr_i[DEPTH_LOG2-1:0];
            wb_data_d = wb_data_i;
        end else if (wb_fire) begin
            cnt_d = CNT_RELOAD;
        end else if (waiting && !stop_i && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end

        if (rd_fire) begin
            read_ready_d = 1'b1;
        end else if (rd_exit) begin
            read_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q        <= 8'd0;
            rd_idx_q     <= '0;
            wb_idx_q     <= '0;
            wb_data_q    <= '0;
            read_ready_q <= 1'b0;
            write_ack_q  <= 1'b0;
            data_out_q   <= '0;
        end else begin
            cnt_q        <= cnt_d;
            rd_idx_q     <= rd_idx_d;
            wb_idx_q     <= wb_idx_d;
            wb_data_q    <= wb_data_d;
            read_ready_q <= read_ready_d;
            write_ack_q  <= write_ack_d;
            if (rd_fire) begin
                data_out_q <= mem_q[rd_idx_q];
            end
        end
    end

    // Storage is never reset; a reset clears state_q, which cancels any pending write.
    always_ff @(posedge clk_i) begin
        if (wb_fire) begin
            mem_q[wb_idx_q] <= wb_data_q;
        end
    end

    assign data_out_o   = data_out_q;
    assign read_ready_o = read_ready_q;
    assign write_ack_o  = write_ack_q;
    assign busy_o       = busy;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Bench for mem_line_ctrl: directed vector table, async-reset abort sequence,
// then randomized transactions checked against a line-array model.
module tb_mem_line_ctrl;

    localparam int L  = 5;
    localparam int DL = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         req;
    logic [25:0]  req_addr;
    logic         wb_en;
    logic [25:0]  wb_addr;
    logic [127:0] wb_data;
    logic         stop;
    logic [127:0] data_out;
    logic         read_ready;
    logic         write_ack;
    logic         busy;

    always #5 clk = ~clk;

    mem_line_ctrl #(.LATENCY(L), .DEPTH_LOG2(DL)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_i        (req),
        .req_addr_i   (req_addr),
        .wb_en_i      (wb_en),
        .wb_addr_i    (wb_addr),
        .wb_data_i    (wb_data),
        .stop_i       (stop),
        .data_out_o   (data_out),
        .read_ready_o (read_ready),
        .write_ack_o  (write_ack),
        .busy_o       (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [127:0] mem_m   [1024];
    bit           known_m [1024];

    typedef struct {
        bit           wbe;
        logic [25:0]  wa;
        logic [127:0] wd;
        logic [25:0]  ra;
        int           s0;
        int           slen;
        bit           drop;
        int           exp_ack;
        int           exp_rdy;
        logic [127:0] exp_d;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One full transaction; edge 0 is the acceptance edge, events are reported by edge number.
    task automatic run_txn(input string tag, input bit wbe, input logic [25:0] wa,
                           input logic [127:0] wd, input logic [25:0] ra,
                           input int s0, input int slen, input bit drop,
                           input int exp_ack, input int exp_rdy,
                           input logic [127:0] exp_d, input bit chk_d);
        int ack_edge = 0;
        int ack_cnt  = 0;
        int rdy_edge = 0;
        int busy_low = 0;
        logic [127:0] got_d = '0;
        @(negedge clk);
        req = 1'b1; wb_en = wbe; wb_addr = wa; wb_data = wd; req_addr = ra; stop = 1'b0;
        @(posedge clk);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy) busy_low++;
            if (n >= 1 && write_ack) begin
                ack_cnt++;
                ack_edge = n;
            end
            if (read_ready) begin
                rdy_edge = n;
                got_d    = data_out;
                break;
            end
            req_addr = 26'($urandom);
            wb_addr  = 26'($urandom);
            wb_data  = {$urandom, $urandom, $urandom, $urandom};
            wb_en    = 1'($urandom);
            stop     = (n >= s0) && (n < s0 + slen);
            req      = (drop && n <= 1) ? 1'b0 : 1'b1;
        end
        stop = 1'b0;
        req  = 1'b1;
        chk({tag, "_busy_low"}, 128'(busy_low), 128'd0);
        chk({tag, "_ack_cnt"}, 128'(ack_cnt), (exp_ack != 0) ? 128'd1 : 128'd0);
        chk({tag, "_ack_edge"}, 128'(ack_edge), 128'(exp_ack));
        chk({tag, "_rdy_edge"}, 128'(rdy_edge), 128'(exp_rdy));
        if (chk_d) chk({tag, "_data"}, got_d, exp_d);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_hold_rdy"}, 128'(read_ready), 128'd1);
        chk({tag, "_hold_data"}, data_out, got_d);
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_drop_rdy"}, 128'(read_ready), 128'd0);
        chk({tag, "_drop_busy"}, 128'(busy), 128'd0);
    endtask

    initial begin
        logic [127:0] p0123, x12, y12;
        int ack_seen;
        int busy_seen;

        p0123 = 128'h0123456789ABCDEF0123456789ABCDEF;
        x12   = 128'hC0FFEE00C0FFEE11C0FFEE22C0FFEE33;
        y12   = 128'hBAD0BAD1BAD2BAD3BAD4BAD5BAD6BAD7;

        tbl[0]  = '{1'b1, 26'd5,        p0123,          26'd5,     0, 0, 1'b0, 5, 10, p0123};
        tbl[1]  = '{1'b0, 26'd0,        128'd0,         26'd5,     0, 0, 1'b0, 0, 5,  p0123};
        tbl[2]  = '{1'b1, 26'd7,        {16{8'h77}},    26'd7,     0, 0, 1'b0, 5, 10, {16{8'h77}}};
        tbl[3]  = '{1'b1, 26'd3,        {16{8'hAA}},    26'd7,     0, 0, 1'b0, 5, 10, {16{8'h77}}};
        tbl[4]  = '{1'b0, 26'd0,        128'd0,         26'd3,     0, 0, 1'b0, 0, 5,  {16{8'hAA}}};
        tbl[5]  = '{1'b1, 26'd9,        {16{8'h55}},    26'd9,     0, 0, 1'b0, 5, 10, {16{8'h55}}};
        tbl[6]  = '{1'b1, 26'h3FFFC00,  {4{32'hDEADBEEF}}, 26'h0000400, 0, 0, 1'b0, 5, 10, {4{32'hDEADBEEF}}};
        tbl[7]  = '{1'b0, 26'd0,        128'd0,         26'h0000400, 0, 0, 1'b0, 0, 5, {4{32'hDEADBEEF}}};
        tbl[8]  = '{1'b0, 26'd0,        128'd0,         26'd5,     1, 3, 1'b0, 0, 8,  p0123};
        tbl[9]  = '{1'b1, 26'd20,       {8{16'hE1E2}},  26'd20,    0, 2, 1'b0, 7, 12, {8{16'hE1E2}}};
        tbl[10] = '{1'b0, 26'd0,        128'd0,         26'd9,     0, 0, 1'b1, 0, 5,  {16{8'h55}}};
        tbl[11] = '{1'b1, 26'd12,       x12,            26'd12,    0, 0, 1'b0, 5, 10, x12};

        for (int i = 0; i < 1024; i++) known_m[i] = 1'b0;

        reset = 1'b1; req = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        req_addr = '0; stop = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data_out", data_out, 128'd0);
        chk("rst_read_ready", 128'(read_ready), 128'd0);
        chk("rst_write_ack", 128'(write_ack), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].wbe, tbl[i].wa, tbl[i].wd, tbl[i].ra,
                    tbl[i].s0, tbl[i].slen, tbl[i].drop, tbl[i].exp_ack, tbl[i].exp_rdy,
                    tbl[i].exp_d, 1'b1);
            if (tbl[i].wbe) begin
                mem_m[tbl[i].wa[9:0]]   = tbl[i].wd;
                known_m[tbl[i].wa[9:0]] = 1'b1;
            end
        end

        // Async reset during WB_WAIT: outputs clear at once and the writeback is lost.
        @(negedge clk);
        req = 1'b1; wb_en = 1'b1; wb_addr = 26'd12; wb_data = y12; req_addr = 26'd12;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_read_ready", 128'(read_ready), 128'd0);
        chk("midrst_write_ack", 128'(write_ack), 128'd0);
        chk("midrst_data_out", data_out, 128'd0);
        @(negedge clk);
        reset = 1'b0; req = 1'b0; wb_en = 1'b0;
        ack_seen  = 0;
        busy_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (write_ack) ack_seen++;
            if (busy) busy_seen++;
        end
        chk("midrst_no_ack", 128'(ack_seen), 128'd0);
        chk("midrst_idle", 128'(busy_seen), 128'd0);
        run_txn("midrst_line12", 1'b0, 26'd0, 128'd0, 26'd12, 0, 0, 1'b0, 0, 5, x12, 1'b1);

        for (int t = 0; t < 40; t++) begin
            bit           wbe;
            logic [25:0]  wa, ra;
            logic [127:0] wd;
            int s0, slen, work, a, r;
            bit drop;
            wbe  = 1'($urandom);
            wa   = {16'($urandom), 10'($urandom_range(0, 31))};
            ra   = {16'($urandom), 10'($urandom_range(0, 31))};
            wd   = {$urandom, $urandom, $urandom, $urandom};
            s0   = $urandom_range(0, 4);
            slen = $urandom_range(0, 4);
            drop = 1'($urandom);
            if (wbe) begin
                mem_m[wa[9:0]]   = wd;
                known_m[wa[9:0]] = 1'b1;
            end
            // Each phase needs L unstalled edges; stalled edges are s0+1 .. s0+slen.
            work = 0; a = 0; r = 0;
            for (int e = 1; r == 0 && e < 100; e++) begin
                if (e > s0 && e <= s0 + slen) continue;
                work++;
                if (wbe && work == L) a = e;
                if (work == (wbe ? 2 * L : L)) r = e;
            end
            run_txn($sformatf("rnd%0d", t), wbe, wa, wd, ra, s0, slen, drop, a, r,
                    mem_m[ra[9:0]], known_m[ra[9:0]]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
